// File: rtl/serial_cmp_ctrl.sv
//==============================================================================
// Module   : serial_cmp_ctrl (with helper module comparator)
// Purpose  : Multi-cycle unsigned magnitude comparator that scans CHUNK-bit
//            slices, MSB first, through one shared comparator, with
//            valid/ready handshakes on both sides.
// Macro    : SERIAL_CMP_EARLY_EXIT_EN - defined: stop at the first unequal
//            slice; undefined: constant-time scan of all N slices.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module comparator #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);
  assign eq = (a == b);
  assign lt = (a < b);
endmodule

module serial_cmp_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic [CHUNK-1:0] w_slices_a [N];
  logic [CHUNK-1:0] w_slices_b [N];
  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic             w_eq;
  logic             w_lt;
  logic             w_last;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign w_slices_a[gi] = r_a[gi*CHUNK +: CHUNK];
      assign w_slices_b[gi] = r_b[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign w_sa   = w_slices_a[r_idx];
  assign w_sb   = w_slices_b[r_idx];
  assign w_last = (r_idx == '0);

  comparator #(.CHUNK(CHUNK)) u_cmp (
    .a  (w_sa),
    .b  (w_sb),
    .eq (w_eq),
    .lt (w_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (in_valid) w_next_state = c_RUN;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      c_RUN:  if (!w_eq || w_last) w_next_state = c_DONE;
`else
      c_RUN:  if (w_last) w_next_state = c_DONE;
`endif
      c_DONE: if (out_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_IDLE);
    out_valid = (r_state == c_DONE);
  end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= c_IDX_LAST;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else if (r_state == c_IDLE) begin
      if (in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_idx <= c_IDX_LAST;
      end
    end else if (r_state == c_RUN) begin
      if (!w_eq) begin
        eq <= 1'b0;
        lt <= w_lt;
      end else if (w_last) begin
        eq <= 1'b1;
        lt <= 1'b0;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end
`else
  // The first differing slice is remembered so later slices cannot override it.
  logic r_decided;
  logic r_dlt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= c_IDX_LAST;
      r_decided <= 1'b0;
      r_dlt     <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else if (r_state == c_IDLE) begin
      if (in_valid) begin
        r_a       <= a;
        r_b       <= b;
        r_idx     <= c_IDX_LAST;
        r_decided <= 1'b0;
        r_dlt     <= 1'b0;
      end
    end else if (r_state == c_RUN) begin
      if (w_last) begin
        if (r_decided) begin
          eq <= 1'b0;
          lt <= r_dlt;
        end else begin
          eq <= w_eq;
          lt <= !w_eq && w_lt;
        end
      end else begin
        if (!r_decided && !w_eq) begin
          r_decided <= 1'b1;
          r_dlt     <= w_lt;
        end
        r_idx <= r_idx - 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
//==============================================================================
// Module   : tb_serial_cmp_ctrl
// Purpose  : Self-checking bench for serial_cmp_ctrl (WIDTH=16, CHUNK=4),
//            honouring SERIAL_CMP_EARLY_EXIT_EN for expected latency.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_cmp_ctrl;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             eq;
  logic             lt;

  int n_checks = 0;
  int n_fail   = 0;

  serial_cmp_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  // Reference latency: slices examined before a decision is reached.
  function automatic int exp_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = 0; i < N; i++)
      if (x[(N-1-i)*CHUNK +: CHUNK] != y[(N-1-i)*CHUNK +: CHUNK]) return i + 1;
    return N;
`else
    return N;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand pair, waits for the result, holds backpressure for
  // 'hold' cycles, then completes the output handshake.
  task automatic do_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input bit scramble, input int hold,
                        output int k, output logic eq_o, output logic lt_o,
                        output bit timed_out);
    k = 0;
    timed_out = 1'b0;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    tick();
    in_valid = 1'b0;
    a = scramble ? 16'hFFFF : WIDTH'($urandom);
    b = scramble ? 16'hFFFF : WIDTH'($urandom);
    while (!out_valid && k < N + 4) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_in_ready: got %b expected 0 (k=%0d)", in_ready, k);
      end
      tick();
      k++;
    end
    if (!out_valid) begin
      timed_out = 1'b1;
      n_checks++;
      n_fail++;
      $display("FAIL timeout: out_valid not seen after %0d cycles", k);
      return;
    end
    eq_o = eq;
    lt_o = lt;
    for (int h = 0; h < hold; h++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || eq !== eq_o || lt !== lt_o || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b eq=%b lt=%b rdy=%b expected v=1 eq=%b lt=%b rdy=0",
                 out_valid, eq, lt, in_ready, eq_o, lt_o);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic check_txn(input string name, input logic [WIDTH-1:0] ta,
                           input logic [WIDTH-1:0] tb, input bit scramble, input int hold);
    int k; logic e, l; bit to;
    int ek; logic ee, el;
    ek = exp_k(ta, tb);
    ee = (ta == tb);
    el = (ta < tb);
    do_txn(ta, tb, scramble, hold, k, e, l, to);
    if (!to) begin
      n_checks++;
      if (k != ek || e !== ee || l !== el) begin
        n_fail++;
        $display("FAIL %s: a=%h b=%h got k=%0d eq=%b lt=%b expected k=%0d eq=%b lt=%b",
                 name, ta, tb, k, e, l, ek, ee, el);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0002;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || eq !== 1'b0 || lt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b eq=%b lt=%b expected 1 0 0 0",
               in_ready, out_valid, eq, lt);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_equal();
    check_txn("equal", 16'h1234, 16'h1234, 1'b0, 0);
    check_txn("equal_zero", 16'h0000, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_msb_diff();
    check_txn("msb_gt", 16'h8000, 16'h7FFF, 1'b0, 0);
    check_txn("msb_lt", 16'h7FFF, 16'h8000, 1'b0, 0);
  endtask

  task automatic test_lsb_capture();
    check_txn("lsb_capture", 16'h1230, 16'h1231, 1'b1, 0);
    check_txn("lsb_capture_gt", 16'h1231, 16'h1230, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    check_txn("backpressure", 16'h0001, 16'h0002, 1'b0, 5);
    check_txn("after_bp", 16'hFFFF, 16'hFFFF, 1'b0, 0);
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h1111;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
    for (int i = 0; i < N + 2; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_run_discard: got out_valid=1 expected no result");
    end
    check_txn("after_reset", 16'h0000, 16'h0001, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [WIDTH-1:0] ra, rb;
      int s;
      ra = WIDTH'($urandom);
      s = int'($urandom_range(0, N));
      if (s == N) rb = ra;
      else rb = ra ^ WIDTH'(($urandom_range(1, (1 << CHUNK) - 1) << (s * CHUNK)) |
                            ($urandom & ((1 << (s * CHUNK)) - 1)));
      check_txn("random", ra, rb, 1'b0, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msb_diff();
    test_lsb_capture();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
- Multi-cycle magnitude comparator for wide unsigned operands. Shares one `comparator #(CHUNK)` instance (ports a, b, eq, lt) across all CHUNK-bit slices.
- Scans slices one per cycle, MSB slice first, and stops at the first unequal slice.
- Sits between a producer and a consumer, each with its own valid/ready handshake. Replaces a full-width combinational comparator where area or timing matters.

Parameters:
WIDTH, 32, operand width in bits; must be a positive multiple of CHUNK
CHUNK, 8, slice width fed to the shared comparator; N = WIDTH/CHUNK slices, N >= 1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair a/b is valid
in_ready  output  1  block can accept an operand pair
a  input  WIDTH  first operand (unsigned)
b  input  WIDTH  second operand (unsigned)
out_valid  output  1  eq/lt hold a valid result
out_ready  input  1  consumer accepts the result
eq  output  1  a == b
lt  output  1  a < b (unsigned)

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, eq=0, lt=0, slice index=N-1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: register a and b into internal operand registers, set idx=N-1, go to RUN.
  - a and b may change freely after acceptance.
- RUN:
  - in_ready=0, out_valid=0.
  - Shared comparator sees slice idx of the registered operands: bits [idx*CHUNK +: CHUNK].
  - If slice eq=0: register eq=0, lt=slice lt, go to DONE.
  - Else if idx==0: register eq=1, lt=0, go to DONE.
  - Else: idx <= idx-1, stay in RUN.
- DONE:
  - out_valid=1; eq and lt stable.
  - When out_ready=1 on an edge: go to IDLE, out_valid drops on the next cycle.
  - Without out_ready, hold indefinitely with outputs unchanged.
- Latency:
  - Accept edge E0; out_valid rises at edge Ek, where k = number of slices examined (1..N).
  - Equal operands always take k=N.
  - The accept-to-accept minimum is k+2 edges; there is no input/output overlap.
- eq/lt after the handshake: keep their last values after DONE→IDLE; they are meaningful only while out_valid=1.
- No simultaneous accept and output: in_ready=0 whenever state != IDLE.
- N=1: single RUN cycle; behaviour is identical to a registered full comparator.
- rst asserted in any state, including mid-RUN or in DONE with out_valid=1: next state is IDLE with reset values. The in-flight operation is discarded and no result is emitted.
- The RUN counter never underflows, because the idx==0 case always exits.

Optional Feature:
SERIAL_CMP_EARLY_EXIT_EN
- Defined: early exit as described above; latency is k = index of the first differing slice counted from the MSB, range 1..N.
- Undefined: constant-time mode.
  - RUN always scans all N slices, so out_valid always rises at EN.
  - The first unequal slice still determines the result. It is latched into a sticky "decided" flag together with its lt value; later slices are ignored.
  - eq = 1 only if no slice differed.

Test Plan:
(WIDTH=16, CHUNK=4, N=4 unless noted)
- Reset: hold rst=1 for 2 edges with in_valid=1 → in_ready=1, out_valid=0, eq=0, lt=0; no transaction accepted.
- Equal operands: a=0x1234, b=0x1234, out_ready=1 → out_valid at E4, eq=1, lt=0; in_ready=1 again by E6. The result is the same with the macro defined or undefined.
- MSB-slice difference: a=0x8000, b=0x7FFF → eq=0, lt=0. Macro defined: out_valid at E1. Macro undefined: out_valid at E4. Repeat with a and b swapped → lt=1.
- LSB-slice difference with operands changed after accept: a=0x1230, b=0x1231, then drive a=b=0xFFFF at E1 → eq=0, lt=1 at E4, proving the operands were captured.
- Backpressure: a=0x0001, b=0x0002, hold out_ready=0 for 5 cycles after out_valid → out_valid, eq=0, lt=1 stable and in_ready=0 throughout. Raise out_ready → IDLE next edge, and a new pair a=0xFFFF, b=0xFFFF is accepted.
- Reset mid-RUN: accept a=0x1111, b=0x1111, assert rst at E2 → IDLE after that edge, out_valid never asserts. A following pair a=0x0000, b=0x0001 completes normally with lt=1 at E4.
